// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, credit-limited word reads to a synchronous imem, head-registered output FIFO.
// Optional INS_FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module ins_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] p_count,
    output logic        ins_valid,
    input  logic        ins_ready
`ifdef INS_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t        state, state_n;
    logic [31:0]   fetch_pc;
    logic          rsp_vld;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count, count_n, wr_idx;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [31:0]   data_n [FIFO_DEPTH];
    logic [31:0]   pc_n   [FIFO_DEPTH];
    logic          pop, push, issue;
    logic [CW:0]   pend;
    logic [31:0]   tgt;

    // Shift FIFO: entry 0 is the head and drives the outputs directly.
    always_comb begin
        pop    = ins_valid & ins_ready;
        push   = rsp_vld & ~redirect;
        tgt    = redirect_pc & ~32'd3;
        wr_idx = count - CW'(pop);
        data_n = data_q;
        pc_n   = pc_q;
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                data_n[i] = data_q[i+1];
                pc_n[i]   = pc_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    data_n[i] = imem_rdata;
                    pc_n[i]   = rsp_pc;
                end
            end
        end
        count_n = redirect ? '0 : wr_idx + CW'(push);
        // Words that will occupy the FIFO once the current request returns.
        pend  = {1'b0, count_n} + (CW+1)'(imem_req);
        issue = ~redirect && (state != BOOT) && (pend < (CW+1)'(FIFO_DEPTH));
        if (redirect || state == BOOT)
            state_n = RUN;
        else if (pend + (CW+1)'(issue) == (CW+1)'(FIFO_DEPTH))
            state_n = HOLD;
        else
            state_n = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            fetch_pc  <= PC_RESET;
            imem_req  <= 1'b0;
            imem_addr <= PC_RESET;
            rsp_vld   <= 1'b0;
            rsp_pc    <= '0;
            count     <= '0;
            ins_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state     <= state_n;
            count     <= count_n;
            ins_valid <= (count_n != '0);
            data_q    <= data_n;
            pc_q      <= pc_n;
            // A redirect squashes the response that would arrive next cycle.
            rsp_vld   <= imem_req & ~redirect;
            rsp_pc    <= imem_addr + 32'd4;
            if (redirect) begin
                imem_req  <= 1'b1;
                imem_addr <= tgt;
                fetch_pc  <= tgt + 32'd4;
            end else begin
                imem_req <= issue;
                if (issue) begin
                    imem_addr <= fetch_pc;
                    fetch_pc  <= fetch_pc + 32'd4;
                end
            end
        end
    end

    assign instruction = data_q[0];
    assign p_count     = pc_q[0];

`ifdef INS_FETCH_PERF_EN
    // Squashed = buffered entries left after an accepted handshake plus both pipeline stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect)
                perf_squashed <= perf_squashed + 32'(wr_idx) + 32'(rsp_vld) + 32'(imem_req);
        end
    end
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: instance a (PC_RESET 0, depth 2), instance b (PC_RESET FFFF_FFF8, depth 4).
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ins_ready = 1'b1;

    logic        req_a, vld_a, req_b, vld_b;
    logic [31:0] addr_a, rdata_a, instr_a, pc_a;
    logic [31:0] addr_b, rdata_b, instr_b, pc_b;
`ifdef INS_FETCH_PERF_EN
    logic [31:0] fet_a, sq_a, fet_b, sq_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns word == address, one cycle after the request.
    always_ff @(posedge clk) if (req_a) rdata_a <= addr_a;
    always_ff @(posedge clk) if (req_b) rdata_b <= addr_b;

    ins_fetch #(.PC_RESET(32'h0000_0000), .FIFO_DEPTH(2)) u_a (
        .clk(clk), .reset(reset),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction(instr_a), .p_count(pc_a), .ins_valid(vld_a), .ins_ready(ins_ready)
`ifdef INS_FETCH_PERF_EN
        , .perf_fetched(fet_a), .perf_squashed(sq_a)
`endif
    );

    ins_fetch #(.PC_RESET(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset),
        .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction(instr_b), .p_count(pc_b), .ins_valid(vld_b), .ins_ready(ins_ready)
`ifdef INS_FETCH_PERF_EN
        , .perf_fetched(fet_b), .perf_squashed(sq_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset;
        chk("rst vld_a", 32'(vld_a), 32'd0);
        chk("rst instr_a", instr_a, 32'd0);
        chk("rst pc_a", pc_a, 32'd0);
        chk("rst req_a", 32'(req_a), 32'd0);
        chk("rst addr_a", addr_a, 32'd0);
        chk("rst addr_b", addr_b, 32'hFFFF_FFF8);
        chk("rst vld_b", 32'(vld_b), 32'd0);
`ifdef INS_FETCH_PERF_EN
        chk("rst perf_fetched", fet_a, 32'd0);
        chk("rst perf_squashed", sq_a, 32'd0);
`endif
    endtask

    // Reset was released just before edge 0; ends sampled in cycle 6.
    task automatic start_seq;
        step;
        chk("c0 req_a", 32'(req_a), 32'd0);
        chk("c0 req_b", 32'(req_b), 32'd0);
        step;
        chk("c1 req_a", 32'(req_a), 32'd1);
        chk("c1 addr_a", addr_a, 32'h0);
        chk("c1 addr_b", addr_b, 32'hFFFF_FFF8);
        chk("c1 vld_a", 32'(vld_a), 32'd0);
        step;
        chk("c2 addr_a", addr_a, 32'h4);
        chk("c2 addr_b", addr_b, 32'hFFFF_FFFC);
        chk("c2 vld_a", 32'(vld_a), 32'd0);
        step;
        chk("c3 vld_a", 32'(vld_a), 32'd1);
        chk("c3 instr_a", instr_a, 32'h0);
        chk("c3 pc_a", pc_a, 32'h4);
        chk("c3 req_a", 32'(req_a), 32'd0);
        chk("c3 instr_b", instr_b, 32'hFFFF_FFF8);
        chk("c3 pc_b", pc_b, 32'hFFFF_FFFC);
        chk("c3 addr_b wrap", addr_b, 32'h0);
        step;
        chk("c4 instr_a", instr_a, 32'h4);
        chk("c4 pc_a", pc_a, 32'h8);
        chk("c4 addr_a", addr_a, 32'h8);
        chk("c4 vld_b", 32'(vld_b), 32'd1);
        chk("c4 pc_b wrap", pc_b, 32'h0);
        step;
        chk("c5 vld_a", 32'(vld_a), 32'd0);
        chk("c5 addr_a", addr_a, 32'hC);
        chk("c5 vld_b", 32'(vld_b), 32'd1);
        chk("c5 pc_b", pc_b, 32'h4);
        step;
        chk("c6 instr_a", instr_a, 32'h8);
        chk("c6 pc_a", pc_a, 32'hC);
        chk("c6 req_a", 32'(req_a), 32'd0);
        chk("c6 instr_b", instr_b, 32'h4);
    endtask

    initial begin
        step;
        chk_reset;
        #1 reset = 1'b0;
        start_seq;

        step;
        chk("c7 instr_a", instr_a, 32'hC);
        chk("c7 addr_a", addr_a, 32'h10);
        step;
        chk("c8 vld_a", 32'(vld_a), 32'd0);
        chk("c8 addr_a", addr_a, 32'h14);
        step;
        chk("c9 instr_a", instr_a, 32'h10);

        // Downstream stall: two words held, no further requests.
        ins_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("stall vld_a", 32'(vld_a), 32'd1);
            chk("stall instr_a", instr_a, 32'h10);
            chk("stall pc_a", pc_a, 32'h14);
            chk("stall req_a", 32'(req_a), 32'd0);
        end
        ins_ready = 1'b1;
        step;
        chk("c20 instr_a", instr_a, 32'h14);
        chk("c20 req_a", 32'(req_a), 32'd1);
        chk("c20 addr_a", addr_a, 32'h18);
        step;
        chk("c21 vld_a", 32'(vld_a), 32'd0);
        chk("c21 addr_a", addr_a, 32'h1C);
        step;
        chk("c22 instr_a", instr_a, 32'h18);
        chk("c22 req_a", 32'(req_a), 32'd0);
        step;
        chk("c23 instr_a", instr_a, 32'h1C);
        chk("c23 addr_a", addr_a, 32'h20);

        // Redirect with an accepted handshake and the 0x20 read in flight.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0403;
        step;
        chk("rd vld_a", 32'(vld_a), 32'd0);
        chk("rd req_a", 32'(req_a), 32'd1);
        chk("rd addr_a", addr_a, 32'h400);
`ifdef INS_FETCH_PERF_EN
        chk("perf_fetched 1", fet_a, 32'd8);
        chk("perf_squashed 1", sq_a, 32'd1);
`endif
        redirect = 1'b0;
        step;
        chk("rd+2 vld_a", 32'(vld_a), 32'd0);
        chk("rd+2 addr_a", addr_a, 32'h404);
        step;
        chk("rd+3 vld_a", 32'(vld_a), 32'd1);
        chk("rd+3 instr_a", instr_a, 32'h400);
        chk("rd+3 pc_a", pc_a, 32'h404);

        // Back-to-back redirects: only the last target is ever output.
        ins_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0800;
        step;
        chk("rr1 vld_a", 32'(vld_a), 32'd0);
        chk("rr1 addr_a", addr_a, 32'h800);
        redirect_pc = 32'h0000_0C02;
        step;
        chk("rr2 vld_a", 32'(vld_a), 32'd0);
        chk("rr2 addr_a", addr_a, 32'hC00);
        redirect = 1'b0;
        ins_ready = 1'b1;
        step;
        chk("rr3 vld_a", 32'(vld_a), 32'd0);
        chk("rr3 addr_a", addr_a, 32'hC04);
        step;
        chk("rr4 vld_a", 32'(vld_a), 32'd1);
        chk("rr4 instr_a", instr_a, 32'hC00);
        chk("rr4 pc_a", pc_a, 32'hC04);
`ifdef INS_FETCH_PERF_EN
        chk("perf_fetched 2", fet_a, 32'd10);
        chk("perf_squashed 2", sq_a, 32'd4);
`endif

        // Asynchronous reset mid-cycle, then a full restart.
        #3 reset = 1'b1;
        #1;
        chk_reset;
        step;
        #1 reset = 1'b0;
        start_seq;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
